// File: rtl/pb_run_pkg.sv
// Shared types and default parameter values for the push-button run detector.
package pb_run_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_MATCHED  = 2'd2
  } state_t;

  localparam int PB_NUM_BUTTONS_DEF    = 4;
  localparam int PB_RUN_LENGTH_DEF     = 3;
  localparam int PB_DEBOUNCE_DEPTH_DEF = 10;
  localparam int PB_TICK_DIV_DEF       = 50000;
  localparam int PB_TIMEOUT_TICKS_DEF  = 2000;

endpackage

// File: rtl/pb_debouncer.sv
// One debounced push-button channel: tick-sampled shift register, OR-stretch
// and rising-edge detect. DEBOUNCE_DEPTH must be at least 2.
module pb_debouncer #(
  parameter int DEBOUNCE_DEPTH = 10
) (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic tick,
  input  logic button_n,
  output logic pressed
);

  logic [DEBOUNCE_DEPTH-1:0] shift_r;
  logic                      status_r;
  logic                      status_buf_r;

  // Sample the inverted raw button on each tick; stretch with OR; delay for edge detect.
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      shift_r      <= '0;
      status_r     <= 1'b0;
      status_buf_r <= 1'b0;
    end else begin
      if (tick) begin
        shift_r <= {shift_r[DEBOUNCE_DEPTH-2:0], ~button_n};
      end
      status_r     <= |shift_r;
      status_buf_r <= status_r;
    end
  end

  assign pressed = status_r & ~status_buf_r;

endmodule

// File: rtl/pb_run_detector.sv
// Debounced N-button run detector: tick divider, lowest-index press select, run FSM.
// Optional inactivity timeout is enabled by defining PB_RUN_TIMEOUT_EN.
module pb_run_detector
  import pb_run_pkg::*;
#(
  parameter int NUM_BUTTONS    = PB_NUM_BUTTONS_DEF,
  parameter int RUN_LENGTH     = PB_RUN_LENGTH_DEF,
  parameter int DEBOUNCE_DEPTH = PB_DEBOUNCE_DEPTH_DEF,
  parameter int TICK_DIV       = PB_TICK_DIV_DEF,
  parameter int TIMEOUT_TICKS  = PB_TIMEOUT_TICKS_DEF,
  localparam int IW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1,
  localparam int CW = $clog2(RUN_LENGTH + 1)
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic [NUM_BUTTONS-1:0] PUSH_BUTTON_N_I,
  input  logic                   clear_i,
  output logic [NUM_BUTTONS-1:0] pb_pressed_o,
  output logic [IW-1:0]          run_button_o,
  output logic [CW-1:0]          run_count_o,
  output logic                   matched_o,
  output logic                   match_pulse_o,
  output logic [1:0]             state_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;

  assign tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));

  // Free-running sample-tick divider.
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_deb
    pb_debouncer #(.DEBOUNCE_DEPTH(DEBOUNCE_DEPTH)) u_deb (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .tick       (tick_s),
      .button_n   (PUSH_BUTTON_N_I[gi]),
      .pressed    (pb_pressed_o[gi])
    );
  end

  logic          sel_valid_s;
  logic [IW-1:0] sel_idx_s;

  // Lowest-index edge wins: scanning downward lets lower indices overwrite.
  always_comb begin
    sel_valid_s = |pb_pressed_o;
    sel_idx_s   = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      sel_idx_s = pb_pressed_o[i] ? IW'(i) : sel_idx_s;
    end
  end

  state_t        state_r, state_nx;
  logic [IW-1:0] run_button_r, button_nx;
  logic [CW-1:0] run_count_r, count_nx;
  logic          matched_r, pulse_r, pulse_nx;
  logic          timeout_hit_s;

`ifdef PB_RUN_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
  logic [TOW-1:0] to_cnt_r;

  // Inactivity tick counter; restarts on accepted press or whenever idle.
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      to_cnt_r <= '0;
    end else if (sel_valid_s || (state_nx == S_IDLE)) begin
      to_cnt_r <= '0;
    end else if (tick_s && (to_cnt_r != TOW'(TIMEOUT_TICKS))) begin
      to_cnt_r <= to_cnt_r + TOW'(1);
    end
  end

  assign timeout_hit_s = (state_r != S_IDLE) && (to_cnt_r == TOW'(TIMEOUT_TICKS));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and next-output logic; clear beats press, press beats timeout.
  always_comb begin
    state_nx  = state_r;
    button_nx = run_button_r;
    count_nx  = run_count_r;
    pulse_nx  = 1'b0;
    if (clear_i) begin
      state_nx  = S_IDLE;
      button_nx = '0;
      count_nx  = '0;
    end else if (sel_valid_s) begin
      case (state_r)
        S_IDLE: begin
          state_nx  = S_COUNTING;
          button_nx = sel_idx_s;
          count_nx  = CW'(1);
        end
        S_COUNTING: begin
          if (sel_idx_s == run_button_r) begin
            count_nx = run_count_r + CW'(1);
            if ((run_count_r + CW'(1)) == CW'(RUN_LENGTH)) begin
              state_nx = S_MATCHED;
              pulse_nx = 1'b1;
            end else begin
              state_nx = S_COUNTING;
            end
          end else begin
            button_nx = sel_idx_s;
            count_nx  = CW'(1);
          end
        end
        S_MATCHED: begin
          if (sel_idx_s == run_button_r) begin
            count_nx = CW'(RUN_LENGTH);
          end else begin
            state_nx  = S_COUNTING;
            button_nx = sel_idx_s;
            count_nx  = CW'(1);
          end
        end
        default: begin
          state_nx  = S_IDLE;
          button_nx = '0;
          count_nx  = '0;
        end
      endcase
    end else if (timeout_hit_s) begin
      state_nx  = S_IDLE;
      button_nx = '0;
      count_nx  = '0;
    end else begin
      state_nx = state_r;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      state_r      <= S_IDLE;
      run_button_r <= '0;
      run_count_r  <= '0;
      matched_r    <= 1'b0;
      pulse_r      <= 1'b0;
    end else begin
      state_r      <= state_nx;
      run_button_r <= button_nx;
      run_count_r  <= count_nx;
      matched_r    <= (state_nx == S_MATCHED);
      pulse_r      <= pulse_nx;
    end
  end

  assign run_button_o  = run_button_r;
  assign run_count_o   = run_count_r;
  assign matched_o     = matched_r;
  assign match_pulse_o = pulse_r;
  assign state_o       = state_r;

endmodule
